seq_alu: RTL and testbench
==========================

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width; legal values are powers of two from 4 to 32.
REQ-002 Parameter SW, default $clog2(WIDTH): shift-amount width, derived from WIDTH and never overridden.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  request; sampled only while busy=0.
REQ-006 ALU_OP  input  4  operation code, sampled with start.
REQ-007 in1, in2  input  WIDTH each  operands, sampled with start.
REQ-008 out  output  WIDTH  registered result; holds its value until the next completion.
REQ-009 flags  output  4  registered {carry, zero, sign, overflow}, in that order from bit 3 to bit 0; holds its value until the next completion.
REQ-010 busy  output  1  high while a multi-cycle operation is in progress.
REQ-011 done  output  1  one-cycle pulse, high in the cycle after out/flags update.

Function
REQ-012 Opcodes SHALL be:
- 0 ADD; 1 SUB; 2 AND; 3 OR; 4 XOR
- 5 SHL; 6 SHR (logical); 7 SAR (arithmetic)
- 8 MUL (unsigned, low half to out); 9 ADC (in1+in2+stored carry)
- 10 CMP (SUB flags, out unchanged); 11 NOT in1
- 12-15: out=0, flags=0, done pulses.
REQ-013 States SHALL be IDLE and MUL; start=1 in IDLE with ALU_OP=8 moves to MUL; every other op stays in IDLE.
REQ-014 Single-cycle ops: at the edge where start=1 is sampled in IDLE, out, flags and done=1 SHALL update together (latency 1).
REQ-015 MUL SHALL capture in1/in2 at the start edge, set busy=1, and do one shift-add step per cycle; at the WIDTH-th edge after start, out, flags and done=1 SHALL update, busy=0, and the state returns to IDLE.
REQ-016 start while busy=1 SHALL be ignored, with no queuing; start in the completion cycle of MUL is accepted normally.
REQ-017 ADD/ADC carry SHALL be bit WIDTH of the (WIDTH+1)-bit sum; ADC SHALL use flags[3] as it stood before the op.
REQ-018 SUB/CMP carry SHALL be 1 when in1<in2 unsigned (borrow).
REQ-019 ADD/ADC overflow SHALL be 1 when in1 and in2 share a sign and the result sign differs.
REQ-020 SUB/CMP overflow SHALL be 1 when in1 and in2 differ in sign and the result sign differs from in1.
REQ-021 Shifts SHALL use in2[SW-1:0] as the amount and ignore higher bits of in2.
REQ-022 Shift carry SHALL be the last bit shifted out, and 0 for amount 0; overflow SHALL be 0.
REQ-023 MUL carry and overflow SHALL both be 1 when the high WIDTH bits of the 2*WIDTH product are nonzero.
REQ-024 AND/OR/XOR/NOT SHALL clear carry and overflow.
REQ-025 zero SHALL be (result==0) and sign SHALL be result[WIDTH-1], for every op; for CMP they are computed on the SUB difference.

Reset
REQ-026 rst_n=0 SHALL immediately force out=0, flags=0, busy=0, done=0, state=IDLE and clear the MUL working registers, including mid-MUL abort.
REQ-027 After rst_n rises, the first start SHALL be accepted on the first rising edge.

Verification (WIDTH=8)
REQ-028 ADD 0xFF+0x01 -> out=0x00, flags=4'b1100, done one cycle after start.
REQ-029 SUB 0x80-0x01 -> out=0x7F, flags=4'b0001; then CMP 0x01,0x02 -> out stays 0x7F, flags=4'b1010.
REQ-030 ADD 0xFF+0x01 then ADC 0x01+0x01 -> out=0x03, flags=4'b0000.
REQ-031 MUL 0x10*0x10 -> busy=1 for 8 cycles, a start for ADD issued mid-run is ignored, then out=0x00, flags=4'b1101, done pulses once.
REQ-032 SHL 0x81 by in2=0x09 (amount 1) -> out=0x02, flags=4'b1000; SAR 0x80 by 3 -> out=0xF0, flags=4'b0010.
REQ-033 Assert rst_n=0 during cycle 4 of a MUL -> all outputs become 0 asynchronously, no done pulse, and the next ADD completes normally.

Source files
------------

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle arithmetic, logic and shift ops, plus a
// WIDTH-cycle shift-add unsigned multiplier behind a two-state IDLE/MUL FSM.
module seq_alu #(
   parameter int WIDTH = 8,
   parameter int SW    = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [3:0]       ALU_OP,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   output logic [WIDTH-1:0] out,
   output logic [3:0]       flags,
   output logic             busy,
   output logic             done
);

   localparam int MSB = WIDTH - 1;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_AND = 4'd2;
   localparam logic [3:0] OP_OR  = 4'd3;
   localparam logic [3:0] OP_XOR = 4'd4;
   localparam logic [3:0] OP_SHL = 4'd5;
   localparam logic [3:0] OP_SHR = 4'd6;
   localparam logic [3:0] OP_SAR = 4'd7;
   localparam logic [3:0] OP_MUL = 4'd8;
   localparam logic [3:0] OP_ADC = 4'd9;
   localparam logic [3:0] OP_CMP = 4'd10;
   localparam logic [3:0] OP_NOT = 4'd11;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } state_t;

   state_t state_q, state_d;

   logic [WIDTH-1:0]   out_q, out_d;
   logic [3:0]         flags_q, flags_d;
   logic               done_q, done_d;

   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [SW-1:0]      cnt_q, cnt_d;

   logic               accept;
   logic               mul_last;
   logic [2*WIDTH-1:0] mul_acc_next;
   logic [WIDTH-1:0]   mul_lo;
   logic [WIDTH-1:0]   mul_hi;

   logic [SW-1:0]      sh_amt;
   logic               cin;
   logic [WIDTH:0]     add_sum;
   logic [WIDTH:0]     sub_diff;
   logic [WIDTH:0]     shl_ext;
   logic [WIDTH:0]     shr_ext;
   logic [WIDTH:0]     sar_ext;

   logic [WIDTH-1:0]   alu_res;
   logic               alu_c;
   logic               alu_v;
   logic               alu_wr;
   logic               alu_rsv;

   assign accept = (state_q == ST_IDLE) && start;

   // ---------------------------------------------------------------
   // Single-cycle datapath
   // ---------------------------------------------------------------
   assign sh_amt   = in2[SW-1:0];
   assign cin      = (ALU_OP == OP_ADC) ? flags_q[3] : 1'b0;
   assign add_sum  = {1'b0, in1} + {1'b0, in2} + {{WIDTH{1'b0}}, cin};
   assign sub_diff = {1'b0, in1} - {1'b0, in2};

   // One guard bit beside the operand catches the last bit shifted out.
   assign shl_ext  = {1'b0, in1} << sh_amt;
   assign shr_ext  = {in1, 1'b0} >> sh_amt;
   assign sar_ext  = $unsigned($signed({in1, 1'b0}) >>> sh_amt);

   always_comb begin
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      alu_wr  = 1'b1;
      alu_rsv = 1'b0;
      case (ALU_OP)
         OP_ADD, OP_ADC: begin
            alu_res = add_sum[WIDTH-1:0];
            alu_c   = add_sum[WIDTH];
            alu_v   = (in1[MSB] == in2[MSB]) && (add_sum[MSB] != in1[MSB]);
         end
         OP_SUB, OP_CMP: begin
            alu_res = sub_diff[WIDTH-1:0];
            alu_c   = sub_diff[WIDTH];
            alu_v   = (in1[MSB] != in2[MSB]) && (sub_diff[MSB] != in1[MSB]);
            alu_wr  = (ALU_OP != OP_CMP);
         end
         OP_AND: alu_res = in1 & in2;
         OP_OR:  alu_res = in1 | in2;
         OP_XOR: alu_res = in1 ^ in2;
         OP_NOT: alu_res = ~in1;
         OP_SHL: begin
            alu_res = shl_ext[WIDTH-1:0];
            alu_c   = shl_ext[WIDTH];
         end
         OP_SHR: begin
            alu_res = shr_ext[WIDTH:1];
            alu_c   = shr_ext[0];
         end
         OP_SAR: begin
            alu_res = sar_ext[WIDTH:1];
            alu_c   = sar_ext[0];
         end
         OP_MUL: alu_wr = 1'b0;
         default: alu_rsv = 1'b1;
      endcase
   end

   // ---------------------------------------------------------------
   // Shift-add multiplier step
   // ---------------------------------------------------------------
   assign mul_acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
   assign mul_lo       = mul_acc_next[WIDTH-1:0];
   assign mul_hi       = mul_acc_next[2*WIDTH-1:WIDTH];
   assign mul_last     = (state_q == ST_MUL) && (cnt_q == SW'(WIDTH - 1));

   // ---------------------------------------------------------------
   // FSM: state register, next-state logic, outputs
   // ---------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start && (ALU_OP == OP_MUL)) state_d = ST_MUL;
         ST_MUL:  if (mul_last) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      busy  = (state_q == ST_MUL);
      out   = out_q;
      flags = flags_q;
      done  = done_q;
   end

   // ---------------------------------------------------------------
   // Result, flag and multiplier working registers
   // ---------------------------------------------------------------
   always_comb begin
      out_d    = out_q;
      flags_d  = flags_q;
      done_d   = 1'b0;
      mcand_d  = mcand_q;
      acc_d    = acc_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;

      if (accept) begin
         if (ALU_OP == OP_MUL) begin
            mcand_d  = {{WIDTH{1'b0}}, in1};
            mplier_d = in2;
            acc_d    = '0;
            cnt_d    = '0;
         end else begin
            done_d = 1'b1;
            if (alu_rsv) begin
               out_d   = '0;
               flags_d = 4'b0000;
            end else begin
               if (alu_wr) out_d = alu_res;
               flags_d = {alu_c, (alu_res == '0), alu_res[MSB], alu_v};
            end
         end
      end else if (state_q == ST_MUL) begin
         acc_d    = mul_acc_next;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q + SW'(1);
         if (mul_last) begin
            out_d   = mul_lo;
            flags_d = {(mul_hi != '0), (mul_lo == '0), mul_lo[MSB], (mul_hi != '0)};
            done_d  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q    <= '0;
         flags_q  <= '0;
         done_q   <= 1'b0;
         mcand_q  <= '0;
         acc_q    <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
      end else begin
         out_q    <= out_d;
         flags_q  <= flags_d;
         done_q   <= done_d;
         mcand_q  <= mcand_d;
         acc_q    <= acc_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: tb/tb_seq_alu.sv
// Directed-vector bench for seq_alu at WIDTH=8; expected values are hand-computed.
module tb_seq_alu;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [3:0] ALU_OP;
   logic [7:0] in1;
   logic [7:0] in2;
   logic [7:0] out;
   logic [3:0] flags;
   logic       busy;
   logic       done;

   int n_vec;
   int n_err;

   seq_alu #(.WIDTH(8)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .ALU_OP (ALU_OP),
      .in1    (in1),
      .in2    (in2),
      .out    (out),
      .flags  (flags),
      .busy   (busy),
      .done   (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Single-cycle op: results and done must appear one edge after start,
   // then done drops while out/flags hold.
   task automatic alu(input string tag, input logic [3:0] op, input logic [7:0] a,
                      input logic [7:0] b, input logic [7:0] eo, input logic [3:0] ef);
      start  = 1'b1;
      ALU_OP = op;
      in1    = a;
      in2    = b;
      tick();
      start = 1'b0;
      $display("op %-10s a=%02h b=%02h -> out=%02h flags=%04b done=%0d", tag, a, b, out, flags, done);
      chk({tag, ".out"}, 32'(out), 32'(eo));
      chk({tag, ".flags"}, 32'(flags), 32'(ef));
      chk({tag, ".done"}, 32'(done), 32'd1);
      tick();
      chk({tag, ".done_drop"}, 32'(done), 32'd0);
      chk({tag, ".hold"}, 32'(out), 32'(eo));
   endtask

   // Multiplier: busy for 8 cycles, optional ADD start mid-run that must be ignored.
   task automatic mul(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] prev, input logic [7:0] eo, input logic [3:0] ef,
                      input bit inject);
      start  = 1'b1;
      ALU_OP = 4'd8;
      in1    = a;
      in2    = b;
      tick();
      start = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         chk({tag, ".busy"}, 32'(busy), 32'd1);
         chk({tag, ".no_done"}, 32'(done), 32'd0);
         chk({tag, ".out_held"}, 32'(out), 32'(prev));
         if (inject && k == 3) begin
            start  = 1'b1;
            ALU_OP = 4'd0;
            in1    = 8'h01;
            in2    = 8'h01;
         end
         tick();
         start = 1'b0;
      end
      tick();
      $display("op %-10s a=%02h b=%02h -> out=%02h flags=%04b done=%0d", tag, a, b, out, flags, done);
      chk({tag, ".out"}, 32'(out), 32'(eo));
      chk({tag, ".flags"}, 32'(flags), 32'(ef));
      chk({tag, ".done"}, 32'(done), 32'd1);
      chk({tag, ".busy_end"}, 32'(busy), 32'd0);
      tick();
      chk({tag, ".done_once"}, 32'(done), 32'd0);
      chk({tag, ".hold"}, 32'(out), 32'(eo));
   endtask

   initial begin
      n_vec  = 0;
      n_err  = 0;
      rst_n  = 1'b1;
      start  = 1'b0;
      ALU_OP = 4'd0;
      in1    = 8'h00;
      in2    = 8'h00;
      #2 rst_n = 1'b0;
      tick();
      tick();
      chk("reset.out", 32'(out), 32'h0);
      chk("reset.flags", 32'(flags), 32'h0);
      chk("reset.busy", 32'(busy), 32'h0);
      chk("reset.done", 32'(done), 32'h0);
      rst_n = 1'b1;

      // First start right after reset release is taken on the first edge.
      alu("add_wrap", 4'd0,  8'hFF, 8'h01, 8'h00, 4'b1100);
      alu("sub_ovf",  4'd1,  8'h80, 8'h01, 8'h7F, 4'b0001);
      alu("cmp",      4'd10, 8'h01, 8'h02, 8'h7F, 4'b1010);
      alu("add_c",    4'd0,  8'hFF, 8'h01, 8'h00, 4'b1100);
      alu("adc_c1",   4'd9,  8'h01, 8'h01, 8'h03, 4'b0000);
      alu("adc_c0",   4'd9,  8'h7F, 8'h01, 8'h80, 4'b0011);
      alu("and",      4'd2,  8'hF0, 8'h3C, 8'h30, 4'b0000);
      alu("or_zero",  4'd3,  8'h00, 8'h00, 8'h00, 4'b0100);
      alu("xor",      4'd4,  8'hAA, 8'h55, 8'hFF, 4'b0010);
      alu("not",      4'd11, 8'h0F, 8'hFF, 8'hF0, 4'b0010);
      alu("shl_amt9", 4'd5,  8'h81, 8'h09, 8'h02, 4'b1000);
      alu("shl7_c0",  4'd5,  8'h01, 8'h07, 8'h80, 4'b0010);
      alu("shl7_c1",  4'd5,  8'h03, 8'h07, 8'h80, 4'b1010);
      alu("shr_amt0", 4'd6,  8'h81, 8'h00, 8'h81, 4'b0010);
      alu("shr1",     4'd6,  8'h81, 8'h01, 8'h40, 4'b1000);
      alu("sar3",     4'd7,  8'h80, 8'h03, 8'hF0, 4'b0010);
      alu("sar1_c",   4'd7,  8'h81, 8'h01, 8'hC0, 4'b1010);
      alu("rsv12",    4'd12, 8'hFF, 8'hFF, 8'h00, 4'b0000);
      alu("sub_bor",  4'd1,  8'h01, 8'h02, 8'hFF, 4'b1010);
      alu("rsv15",    4'd15, 8'h12, 8'h34, 8'h00, 4'b0000);

      mul("mul_c3",   8'h0F, 8'h0D, 8'h00, 8'hC3, 4'b0010, 1'b0);
      mul("mul_100",  8'h10, 8'h10, 8'hC3, 8'h00, 4'b1101, 1'b1);
      mul("mul_ffff", 8'hFF, 8'hFF, 8'h00, 8'h01, 4'b1001, 1'b0);

      // Abort a multiply part-way: outputs clear without waiting for an edge.
      alu("pre_abort", 4'd1, 8'h01, 8'h02, 8'hFF, 4'b1010);
      start  = 1'b1;
      ALU_OP = 4'd8;
      in1    = 8'hFF;
      in2    = 8'hFF;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      chk("abort.busy_before", 32'(busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("abort.out", 32'(out), 32'h0);
      chk("abort.flags", 32'(flags), 32'h0);
      chk("abort.busy", 32'(busy), 32'h0);
      chk("abort.done", 32'(done), 32'h0);
      tick();
      chk("abort.done_hold", 32'(done), 32'h0);
      rst_n = 1'b1;
      chk("abort.idle", 32'(busy), 32'h0);
      alu("post_add", 4'd0, 8'h12, 8'h34, 8'h46, 4'b0000);
      alu("add_ovf",  4'd0, 8'h7F, 8'h01, 8'h80, 4'b0011);
      tick();
      tick();
      chk("final.no_done", 32'(done), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
